msft_mem_lane_adapter: RTL and testbench
========================================

// Module: msft_mem_lane_adapter
// PURPOSE
//  Sits between a 32-bit-lane CHERIoT core port and a wider memory/bus port (N x 32 data + tag).
//  Tracks the lane of every accepted request in order, up to MaxOutstanding in flight.
//  Steers returned read data to the core lane; replicates write data and shifts byte enables.
//  Replaces the single latched address-bit lane select, which is only correct with one outstanding
//  request per port. One instance per port (instr, data, tsmap).
// PARAMETERS
//  Lanes           2     32-bit lanes per memory word (power of 2, >=1; 1 => pure pass-through + tracking)
//  TagW            1     tag bits carried at MSB of both data words (0 or 1)
//  MaxOutstanding  4     max accepted-but-unanswered requests (>=1)
//  AddrW           32    address width
// PORTS
//  clk_i            in   1            clock
//  rstn_i           in   1            reset, asynchronous, active-low
//  core_req_i       in   1            core request
//  core_gnt_o       out  1            core grant
//  core_we_i        in   1            write enable
//  core_be_i        in   4            byte enables (32-bit lane)
//  core_addr_i      in   AddrW        byte address
//  core_wdata_i     in   32+TagW      write data {tag,data}
//  core_rvalid_o    out  1            response valid
//  core_rdata_o     out  32+TagW      response data {tag,lane data}
//  core_err_o       out  1            response error
//  mem_req_o        out  1            memory request
//  mem_gnt_i        in   1            memory grant
//  mem_we_o         out  1            write enable
//  mem_be_o         out  4*Lanes      byte enables
//  mem_addr_o       out  AddrW        address (= core_addr_i, unmodified)
//  mem_wdata_o      out  32*Lanes+TagW  write data
//  mem_rvalid_i     in   1            memory response valid
//  mem_rdata_i      in   32*Lanes+TagW  memory response data
//  mem_err_i        in   1            memory response error
//  outstanding_o    out  $clog2(MaxOutstanding+1)  in-flight count
//  unexp_rsp_o      out  1            sticky: mem_rvalid_i seen with nothing outstanding
// BEHAVIOUR
//  - Reset: FIFO flushed; count=0; unexp_rsp_o=0. Comb outputs follow inputs with empty FIFO.
//  - lane = core_addr_i[$clog2(Lanes)+1:2]; 0 when Lanes==1.
//  - full = (count==MaxOutstanding). mem_req_o = core_req_i & ~full. core_gnt_o = mem_gnt_i & ~full.
//  - Full blocks regardless of a same-cycle mem_rvalid_i; no comb path rvalid->req/gnt.
//  - Push lane into FIFO on mem_req_o & mem_gnt_i; pop on mem_rvalid_i & ~empty.
//  - Push and pop in the same cycle: count unchanged; order preserved.
//  - Pointers wrap modulo MaxOutstanding.
//  - Write: mem_wdata_o = {tag, Lanes copies of core data}.
//  - Write: mem_be_o = core_be_i << 4*lane, zero elsewhere. mem_we_o/mem_addr_o pass through.
//  - Read, 0-cycle latency: core_rvalid_o = mem_rvalid_i; core_err_o = mem_err_i.
//  - Read: core_rdata_o = {mem tag, mem_rdata_i lane[head]}; tag is returned for every lane.
//  - Writes also occupy a FIFO slot; the memory returns one rvalid per request.
//  - mem_rvalid_i with an empty FIFO: forwarded using lane 0; unexp_rsp_o set; sticky until reset.
//  - Reset mid-operation discards in-flight entries. Responses after reset are unexpected.
//  - Core must hold req/addr/we/be/wdata stable until granted (standard ibex protocol).
// STRUCTURE
//  - Package msft_mem_adapt_pkg: LaneW = (Lanes>1)?$clog2(Lanes):1; lane_idx_t; CntW function.
//  - Sub-module msft_lane_idx_fifo #(Depth, W): flop FIFO, push/pop/full/empty/count.
//  - Top: lane decode, be shift, wdata replicate, rdata mux, sticky flag.
// TESTING
//  1. Lanes=2: read addr 0x4 granted, rvalid with rdata[64:0]={1,0xAAAA_0000_BBBB_1111}
//     -> core_rdata_o={1,0xAAAA_0000}.
//  2. Back-to-back reads 0x0,0x4,0x8 granted on 3 cycles, rvalids delayed 3 cycles
//     -> lanes 0,1,0 in order.
//  3. MaxOutstanding=4, 4 grants with no rvalid -> 5th req: mem_req_o=0, core_gnt_o=0.
//     One rvalid -> next cycle granted.
//  4. Write addr 0xC, be=0x3, wdata=0x1234_5678 -> mem_be_o=0x30,
//     mem_wdata_o[63:0]=0x1234_5678_1234_5678.
//  5. rvalid when outstanding_o=0 -> core_rvalid_o=1, lane 0 data, unexp_rsp_o=1 held until reset.
//  6. Simultaneous push+pop at count=2 -> count stays 2. Reset with 3 in flight -> count=0, flag 0.

Source files
------------

// File: rtl/msft_mem_adapt_pkg.sv
// Shared widths and helpers for the core-lane to wide-memory adapter.
// Lane index sizing and counter sizing used by the adapter and its FIFO.
package msft_mem_adapt_pkg;

    localparam int unsigned DefLanes = 2;

    function automatic int unsigned lane_w(input int unsigned lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    localparam int unsigned LaneW = lane_w(DefLanes);

    typedef logic [LaneW-1:0] lane_idx_t;

endpackage

// File: rtl/msft_lane_idx_fifo.sv
// In-order FIFO of lane indices, one entry per accepted request.
// Pointers wrap modulo Depth; push is refused when full, pop when empty.
module msft_lane_idx_fifo
    import msft_mem_adapt_pkg::*;
#(
    parameter int unsigned Depth = 4,
    parameter int unsigned W     = 1
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic                      push,
    input  logic [W-1:0]              push_data,
    input  logic                      pop,
    output logic [W-1:0]              head,
    output logic                      full,
    output logic                      empty,
    output logic [cnt_w(Depth)-1:0]   count
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = cnt_w(Depth);

    logic [W-1:0]    slots [Depth];
    logic [PtrW-1:0] wr_ptr;
    logic [PtrW-1:0] rd_ptr;
    logic [CntW-1:0] cnt;
    logic            do_push;
    logic            do_pop;

    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (cnt == CntW'(Depth));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign head    = slots[rd_ptr];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Storage needs no reset; validity is carried by the count.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            slots[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy tracking; simultaneous push/pop keeps the count.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            unique case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CntW'(1);
                2'b01:   cnt <= cnt - CntW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/msft_mem_lane_adapter.sv
// Adapts a 32-bit core lane port to an N-lane memory port.
// Remembers each request's lane so responses steer correctly with many in flight.
module msft_mem_lane_adapter
    import msft_mem_adapt_pkg::*;
#(
    parameter int unsigned Lanes          = 2,
    parameter int unsigned TagW           = 1,
    parameter int unsigned MaxOutstanding = 4,
    parameter int unsigned AddrW          = 32
) (
    input  logic                               clk_i,
    input  logic                               rstn_i,
    input  logic                               core_req_i,
    output logic                               core_gnt_o,
    input  logic                               core_we_i,
    input  logic [3:0]                         core_be_i,
    input  logic [AddrW-1:0]                   core_addr_i,
    input  logic [32+TagW-1:0]                 core_wdata_i,
    output logic                               core_rvalid_o,
    output logic [32+TagW-1:0]                 core_rdata_o,
    output logic                               core_err_o,
    output logic                               mem_req_o,
    input  logic                               mem_gnt_i,
    output logic                               mem_we_o,
    output logic [4*Lanes-1:0]                 mem_be_o,
    output logic [AddrW-1:0]                   mem_addr_o,
    output logic [32*Lanes+TagW-1:0]           mem_wdata_o,
    input  logic                               mem_rvalid_i,
    input  logic [32*Lanes+TagW-1:0]           mem_rdata_i,
    input  logic                               mem_err_i,
    output logic [cnt_w(MaxOutstanding)-1:0]   outstanding_o,
    output logic                               unexp_rsp_o
);

    localparam int unsigned LW  = lane_w(Lanes);
    localparam int unsigned BeW = 4 * Lanes;

    logic [LW-1:0] lane;
    logic [LW-1:0] head;
    logic [LW-1:0] sel;
    logic [31:0]   lane_data;
    logic          full;
    logic          empty;
    logic          push;

    if (Lanes > 1) begin : g_lane
        assign lane = core_addr_i[LW+1:2];
    end else begin : g_single
        assign lane = '0;
    end

    // Full blocks new requests even when a response retires an entry this cycle.
    assign mem_req_o  = core_req_i & ~full;
    assign core_gnt_o = mem_gnt_i & ~full;
    assign push       = mem_req_o & mem_gnt_i;

    assign mem_we_o   = core_we_i;
    assign mem_addr_o = core_addr_i;
    assign mem_be_o   = BeW'(core_be_i) << {lane, 2'b00};

    // Unmatched responses fall back to lane 0.
    assign sel        = empty ? '0 : head;
    assign lane_data  = mem_rdata_i[32*sel +: 32];

    assign core_rvalid_o = mem_rvalid_i;
    assign core_err_o    = mem_err_i;

    if (TagW > 0) begin : g_tag
        assign mem_wdata_o  = {core_wdata_i[32 +: TagW],
                               {Lanes{core_wdata_i[31:0]}}};
        assign core_rdata_o = {mem_rdata_i[32*Lanes +: TagW], lane_data};
    end else begin : g_notag
        assign mem_wdata_o  = {Lanes{core_wdata_i[31:0]}};
        assign core_rdata_o = lane_data;
    end

    msft_lane_idx_fifo #(
        .Depth (MaxOutstanding),
        .W     (LW)
    ) u_fifo (
        .clk_i     (clk_i),
        .rstn_i    (rstn_i),
        .push      (push),
        .push_data (lane),
        .pop       (mem_rvalid_i),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .count     (outstanding_o)
    );

    // Sticky record of a response arriving with nothing outstanding.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            unexp_rsp_o <= 1'b0;
        end else if (mem_rvalid_i && empty) begin
            unexp_rsp_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_msft_mem_lane_adapter.sv
// Randomized and directed bench for msft_mem_lane_adapter (Lanes=2, TagW=1).
// Reference model: a queue of lane numbers plus a sticky flag.
module tb_msft_mem_lane_adapter;

    localparam int unsigned Lanes = 2;
    localparam int unsigned TagW  = 1;
    localparam int unsigned MaxO  = 4;
    localparam int unsigned AddrW = 32;
    localparam int unsigned CW    = 33;
    localparam int unsigned MW    = 65;

    logic            clk_i;
    logic            rstn_i;
    logic            core_req_i;
    logic            core_gnt_o;
    logic            core_we_i;
    logic [3:0]      core_be_i;
    logic [31:0]     core_addr_i;
    logic [CW-1:0]   core_wdata_i;
    logic            core_rvalid_o;
    logic [CW-1:0]   core_rdata_o;
    logic            core_err_o;
    logic            mem_req_o;
    logic            mem_gnt_i;
    logic            mem_we_o;
    logic [7:0]      mem_be_o;
    logic [31:0]     mem_addr_o;
    logic [MW-1:0]   mem_wdata_o;
    logic            mem_rvalid_i;
    logic [MW-1:0]   mem_rdata_i;
    logic            mem_err_i;
    logic [2:0]      outstanding_o;
    logic            unexp_rsp_o;

    int checks = 0;
    int errors = 0;

    int q[$];
    bit unexp_m;

    msft_mem_lane_adapter #(
        .Lanes          (Lanes),
        .TagW           (TagW),
        .MaxOutstanding (MaxO),
        .AddrW          (AddrW)
    ) dut (
        .clk_i         (clk_i),
        .rstn_i        (rstn_i),
        .core_req_i    (core_req_i),
        .core_gnt_o    (core_gnt_o),
        .core_we_i     (core_we_i),
        .core_be_i     (core_be_i),
        .core_addr_i   (core_addr_i),
        .core_wdata_i  (core_wdata_i),
        .core_rvalid_o (core_rvalid_o),
        .core_rdata_o  (core_rdata_o),
        .core_err_o    (core_err_o),
        .mem_req_o     (mem_req_o),
        .mem_gnt_i     (mem_gnt_i),
        .mem_we_o      (mem_we_o),
        .mem_be_o      (mem_be_o),
        .mem_addr_o    (mem_addr_o),
        .mem_wdata_o   (mem_wdata_o),
        .mem_rvalid_i  (mem_rvalid_i),
        .mem_rdata_i   (mem_rdata_i),
        .mem_err_i     (mem_err_i),
        .outstanding_o (outstanding_o),
        .unexp_rsp_o   (unexp_rsp_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [71:0] got,
                       input logic [71:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit req, input bit we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [CW-1:0] wd,
                         input bit gnt, input bit rv,
                         input logic [MW-1:0] rd, input bit err);
        core_req_i   = req;
        core_we_i    = we;
        core_be_i    = be;
        core_addr_i  = addr;
        core_wdata_i = wd;
        mem_gnt_i    = gnt;
        mem_rvalid_i = rv;
        mem_rdata_i  = rd;
        mem_err_i    = err;
        #1;
    endtask

    // Compare every output against what the lane rules imply.
    task automatic check_model();
        bit          full;
        int          ln;
        int          rl;
        logic [7:0]  be;
        logic [31:0] d;
        full = (q.size() == MaxO);
        ln   = (core_addr_i >> 2) % Lanes;
        rl   = (q.size() > 0) ? q[0] : 0;
        be   = 8'(core_be_i) << (4 * ln);
        d    = core_wdata_i[31:0];
        chk("req", 72'(mem_req_o), 72'(core_req_i && !full));
        chk("gnt", 72'(core_gnt_o), 72'(mem_gnt_i && !full));
        chk("we", 72'(mem_we_o), 72'(core_we_i));
        chk("addr", 72'(mem_addr_o), 72'(core_addr_i));
        chk("be", 72'(mem_be_o), 72'(be));
        chk("wdata", 72'(mem_wdata_o), 72'({core_wdata_i[32], d, d}));
        chk("rvalid", 72'(core_rvalid_o), 72'(mem_rvalid_i));
        chk("err", 72'(core_err_o), 72'(mem_err_i));
        chk("rdata", 72'(core_rdata_o),
            72'({mem_rdata_i[64], mem_rdata_i[32*rl +: 32]}));
        chk("count", 72'(outstanding_o), 72'(q.size()));
        chk("unexp", 72'(unexp_rsp_o), 72'(unexp_m));
    endtask

    task automatic step();
        bit push;
        bit pop;
        bit miss;
        int ln;
        push = core_req_i && mem_gnt_i && (q.size() < MaxO);
        pop  = mem_rvalid_i && (q.size() > 0);
        miss = mem_rvalid_i && (q.size() == 0);
        ln   = (core_addr_i >> 2) % Lanes;
        @(posedge clk_i);
        if (pop) void'(q.pop_front());
        if (push) q.push_back(ln);
        if (miss) unexp_m = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic idle();
        drive(0, 0, 4'h0, 32'h0, '0, 0, 0, '0, 0);
    endtask

    task automatic rd_req(input logic [31:0] a);
        drive(1, 0, 4'hF, a, '0, 1, 0, '0, 0);
        check_model();
        step();
    endtask

    task automatic rsp(input logic [MW-1:0] rd);
        drive(0, 0, 4'h0, 32'h0, '0, 0, 1, rd, 0);
        check_model();
        step();
    endtask

    logic [MW-1:0] pat;
    bit            r_req;
    bit            r_we;
    logic [3:0]    r_be;
    logic [31:0]   r_addr;
    logic [CW-1:0] r_wd;
    bit            r_gnt;
    bit            r_rv;
    logic [MW-1:0] r_rd;
    bit            taken;

    initial begin
        unexp_m = 1'b0;
        rstn_i  = 1'b0;
        idle();
        chk("rst_count", 72'(outstanding_o), 72'd0);
        chk("rst_unexp", 72'(unexp_rsp_o), 72'd0);
        @(negedge clk_i);
        rstn_i = 1'b1;
        @(negedge clk_i);

        // Lane 1 read returns upper word with tag.
        rd_req(32'h4);
        drive(0, 0, 4'h0, 32'h0, '0, 0, 1, {1'b1, 64'hAAAA_0000_BBBB_1111}, 0);
        check_model();
        chk("t1_rdata", 72'(core_rdata_o), 72'(33'h1_AAAA_0000));
        step();

        // Three back-to-back reads, delayed responses in order.
        rd_req(32'h0);
        rd_req(32'h4);
        rd_req(32'h8);
        for (int i = 0; i < 3; i++) begin
            idle();
            check_model();
            step();
        end
        pat = {1'b0, 64'hDDDD_0001_CCCC_0000};
        drive(0, 0, 4'h0, 32'h0, '0, 0, 1, pat, 0);
        chk("t2_r0", 72'(core_rdata_o), 72'(33'h0_CCCC_0000));
        step();
        drive(0, 0, 4'h0, 32'h0, '0, 0, 1, pat, 0);
        chk("t2_r1", 72'(core_rdata_o), 72'(33'h0_DDDD_0001));
        step();
        drive(0, 0, 4'h0, 32'h0, '0, 0, 1, pat, 0);
        chk("t2_r2", 72'(core_rdata_o), 72'(33'h0_CCCC_0000));
        step();

        // Fill to the limit; a same-cycle response must not unblock.
        for (int i = 0; i < 4; i++) rd_req(32'(i * 4));
        drive(1, 0, 4'hF, 32'h10, '0, 1, 0, '0, 0);
        chk("t3_req", 72'(mem_req_o), 72'd0);
        chk("t3_gnt", 72'(core_gnt_o), 72'd0);
        drive(1, 0, 4'hF, 32'h10, '0, 1, 1, '0, 0);
        chk("t3_req_rv", 72'(mem_req_o), 72'd0);
        chk("t3_gnt_rv", 72'(core_gnt_o), 72'd0);
        check_model();
        step();
        drive(1, 0, 4'hF, 32'h10, '0, 1, 0, '0, 0);
        chk("t3_regnt", 72'(core_gnt_o), 72'd1);
        check_model();
        step();
        while (q.size() > 0) rsp({1'b0, $urandom(), $urandom()});

        // Write to lane 1 replicates data and shifts enables.
        drive(1, 1, 4'h3, 32'hC, {1'b1, 32'h1234_5678}, 1, 0, '0, 0);
        chk("t4_be", 72'(mem_be_o), 72'h30);
        chk("t4_wdata", 72'(mem_wdata_o), 72'({1'b1, 64'h1234_5678_1234_5678}));
        check_model();
        step();
        rsp('0);

        // Response with nothing in flight.
        drive(0, 0, 4'h0, 32'h0, '0, 0, 1, {1'b0, 64'h5555_6666_7777_8888}, 1);
        chk("t5_rvalid", 72'(core_rvalid_o), 72'd1);
        chk("t5_rdata", 72'(core_rdata_o), 72'(33'h0_7777_8888));
        step();
        idle();
        chk("t5_unexp", 72'(unexp_rsp_o), 72'd1);
        step();
        step();
        chk("t5_hold", 72'(unexp_rsp_o), 72'd1);

        // Push and pop together at count 2.
        rd_req(32'h0);
        rd_req(32'h4);
        drive(1, 0, 4'hF, 32'h8, '0, 1, 1, '0, 0);
        check_model();
        step();
        idle();
        chk("t6_count", 72'(outstanding_o), 72'd2);
        rd_req(32'hC);
        chk("t6_three", 72'(outstanding_o), 72'd3);
        rstn_i = 1'b0;
        #1;
        q.delete();
        unexp_m = 1'b0;
        chk("t6_rst_cnt", 72'(outstanding_o), 72'd0);
        chk("t6_rst_flag", 72'(unexp_rsp_o), 72'd0);
        @(negedge clk_i);
        rstn_i = 1'b1;
        idle();
        check_model();
        step();

        // Random traffic; core holds a request until it is taken.
        r_req = 0;
        taken = 1;
        for (int n = 0; n < 3000; n++) begin
            if (taken || !r_req) begin
                r_req  = ($urandom_range(0, 3) != 0);
                r_we   = $urandom_range(0, 1);
                r_be   = 4'($urandom());
                r_addr = $urandom();
                r_wd   = {1'($urandom()), $urandom()};
            end
            r_gnt = $urandom_range(0, 1);
            r_rv  = (q.size() > 0) && ($urandom_range(0, 2) != 0);
            if (n > 2900) r_rv = $urandom_range(0, 1);
            r_rd  = {1'($urandom()), $urandom(), $urandom()};
            taken = r_req && r_gnt && (q.size() < MaxO);
            drive(r_req, r_we, r_be, r_addr, r_wd, r_gnt, r_rv, r_rd,
                  1'($urandom()));
            check_model();
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
